// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, waits out ROM latency
// and presents each instruction with its PC to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned INCR          = 4,
  parameter int unsigned ROM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     branch_req,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] PcReset = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] PcIncr  = ADDRESS_WIDTH'(INCR);
  localparam logic [2:0]               CntInit = (ROM_LATENCY == 0) ? 3'd0 : 3'(ROM_LATENCY - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                     valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      StIdle: begin
        if (branch_req) pc_d = branch_target;
        if (fetch_en)   state_d = StIssue;
      end

      StIssue: begin
        if (branch_req) begin
          pc_d    = branch_target;
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          state_d = StIssue;
        end else if (ROM_LATENCY == 0) begin
          instr_d    = rom_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = StHold;
        end else begin
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end

      StWait: begin
        // A redirect on the capture cycle wins; the stale data is dropped.
        if (branch_req) begin
          pc_d    = branch_target;
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          state_d = StIssue;
        end else if (cnt_q == 3'd0) begin
          instr_d    = rom_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = StHold;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StHold: begin
        if (branch_req) begin
          pc_d    = branch_target;
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          state_d = StIssue;
        end else if (instr_ready) begin
          pc_d    = pc_q + PcIncr;
          valid_d = 1'b0;
          state_d = fetch_en ? StIssue : StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= PcReset;
      cnt_q      <= 3'd0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == StIssue) || (state_q == StWait);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: three instances at ROM latencies 1, 0 and 3,
// each fed by a ROM model returning addr+0x100 after the matching number of cycles.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic rst, rst3;

  // Latency-1 instance
  logic        fe1, br1, rdy1, valid1, busy1;
  logic [7:0]  bt1, addr1, pc1;
  logic [31:0] rom1, instr1;
  // Latency-0 instance
  logic        fe0, br0, rdy0, valid0, busy0;
  logic [7:0]  bt0, addr0, pc0;
  logic [31:0] rom0, instr0;
  // Latency-3 instance
  logic        fe3, br3, rdy3, valid3, busy3;
  logic [7:0]  bt3, addr3, pc3;
  logic [31:0] rom3, instr3, rom3_a, rom3_b;

  always @(posedge clk) rom1 <= 32'h100 + {24'd0, addr1};
  assign rom0 = 32'h100 + {24'd0, addr0};
  always @(posedge clk) begin
    rom3_a <= 32'h100 + {24'd0, addr3};
    rom3_b <= rom3_a;
    rom3   <= rom3_b;
  end

  fetch_sequencer #(.ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .fetch_en(fe1), .branch_req(br1), .branch_target(bt1),
    .rom_addr(addr1), .rom_data(rom1), .instr(instr1), .instr_pc(pc1),
    .instr_valid(valid1), .instr_ready(rdy1), .busy(busy1)
  );

  fetch_sequencer #(.ROM_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .fetch_en(fe0), .branch_req(br0), .branch_target(bt0),
    .rom_addr(addr0), .rom_data(rom0), .instr(instr0), .instr_pc(pc0),
    .instr_valid(valid0), .instr_ready(rdy0), .busy(busy0)
  );

  fetch_sequencer #(.ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .fetch_en(fe3), .branch_req(br3), .branch_target(bt3),
    .rom_addr(addr3), .rom_data(rom3), .instr(instr3), .instr_pc(pc3),
    .instr_valid(valid3), .instr_ready(rdy3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold1(input string tag, input logic [7:0] pc);
    check({tag, "_valid"}, {31'd0, valid1}, 32'd1);
    check({tag, "_pc"}, {24'd0, pc1}, {24'd0, pc});
    check({tag, "_instr"}, instr1, 32'h100 + {24'd0, pc});
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    fe1 = 1'b1; br1 = 1'b0; bt1 = 8'h00; rdy1 = 1'b1;
    fe0 = 1'b1; br0 = 1'b0; bt0 = 8'h00; rdy0 = 1'b0;
    fe3 = 1'b1; br3 = 1'b0; bt3 = 8'h00; rdy3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_instr", instr1, 32'd0);
    check("rst_pc", {24'd0, pc1}, 32'd0);
    check("rst_addr", {24'd0, addr1}, 32'd0);

    rst = 1'b0;                                        // cycle 0: IDLE
    check("c0_busy", {31'd0, busy1}, 32'd0);
    tick();                                            // cycle 1: ISSUE
    check("c1_busy", {31'd0, busy1}, 32'd1);
    check("c1_valid", {31'd0, valid1}, 32'd0);
    check("l0_c1_busy", {31'd0, busy0}, 32'd1);
    check("l0_c1_valid", {31'd0, valid0}, 32'd0);
    tick();                                            // cycle 2: WAIT
    check("c2_valid", {31'd0, valid1}, 32'd0);
    check("l0_c2_valid", {31'd0, valid0}, 32'd1);
    check("l0_c2_pc", {24'd0, pc0}, 32'd0);
    check("l0_c2_instr", instr0, 32'h100);
    tick();                                            // cycle 3: HOLD
    hold1("c3", 8'h00);
    check("c3_busy", {31'd0, busy1}, 32'd0);
    check("l0_c3_held", {31'd0, valid0}, 32'd1);
    tick();
    check("c4_valid", {31'd0, valid1}, 32'd0);
    check("c4_addr", {24'd0, addr1}, 32'h04);
    tick(); tick();
    hold1("c6", 8'h04);
    tick(); tick(); tick();
    hold1("c9", 8'h08);

    rdy1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hold1("bp", 8'h08);
    end
    rdy1 = 1'b1;
    tick();
    check("bp_rel_valid", {31'd0, valid1}, 32'd0);
    tick(); tick();
    hold1("after_bp", 8'h0C);

    tick();
    check("issue10_addr", {24'd0, addr1}, 32'h10);
    tick();                                            // WAIT of 0x10
    br1 = 1'b1; bt1 = 8'h40;
    tick();
    br1 = 1'b0;
    check("brw_valid", {31'd0, valid1}, 32'd0);
    check("brw_busy", {31'd0, busy1}, 32'd1);
    check("brw_addr", {24'd0, addr1}, 32'h40);
    tick();
    check("brw_wait_valid", {31'd0, valid1}, 32'd0);
    tick();
    hold1("brw", 8'h40);

    // Redirect while held without a handshake squashes the held instruction.
    rdy1 = 1'b0; br1 = 1'b1; bt1 = 8'h20;
    tick();
    br1 = 1'b0; rdy1 = 1'b1;
    check("brh_valid", {31'd0, valid1}, 32'd0);
    check("brh_addr", {24'd0, addr1}, 32'h20);
    tick(); tick();
    hold1("brh", 8'h20);

    br1 = 1'b1; bt1 = 8'h80;
    tick();
    br1 = 1'b0;
    check("brhs_valid", {31'd0, valid1}, 32'd0);
    check("brhs_addr", {24'd0, addr1}, 32'h80);
    tick(); tick();
    hold1("brhs", 8'h80);

    br1 = 1'b1; bt1 = 8'hFC;
    tick();
    br1 = 1'b0;
    tick(); tick();
    hold1("wrap_fc", 8'hFC);
    tick();
    check("wrap_addr", {24'd0, addr1}, 32'h00);
    check("wrap_valid", {31'd0, valid1}, 32'd0);
    tick(); tick();
    hold1("wrap_00", 8'h00);

    fe1 = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy1}, 32'd0);
    check("idle_valid", {31'd0, valid1}, 32'd0);
    check("idle_addr", {24'd0, addr1}, 32'h04);
    br1 = 1'b1; bt1 = 8'h30;
    tick();
    br1 = 1'b0;
    check("idle_br_addr", {24'd0, addr1}, 32'h30);
    check("idle_br_busy", {31'd0, busy1}, 32'd0);
    tick();
    check("idle_stay_busy", {31'd0, busy1}, 32'd0);
    fe1 = 1'b1;
    tick();
    check("idle_go_busy", {31'd0, busy1}, 32'd1);
    tick(); tick();
    hold1("idle_go", 8'h30);

    // Latency-3 instance and asynchronous reset in the middle of WAIT.
    rst3 = 1'b0;                                       // cycle 0
    tick();
    check("l3_c1_busy", {31'd0, busy3}, 32'd1);
    tick(); tick(); tick();
    check("l3_c4_valid", {31'd0, valid3}, 32'd0);
    tick();
    check("l3_c5_valid", {31'd0, valid3}, 32'd1);
    check("l3_c5_pc", {24'd0, pc3}, 32'h00);
    check("l3_c5_instr", instr3, 32'h100);
    tick();
    check("l3_c6_addr", {24'd0, addr3}, 32'h04);
    tick(); tick(); tick();
    check("l3_c9_valid", {31'd0, valid3}, 32'd0);
    tick();
    check("l3_c10_valid", {31'd0, valid3}, 32'd1);
    check("l3_c10_pc", {24'd0, pc3}, 32'h04);
    check("l3_c10_instr", instr3, 32'h104);
    tick(); tick(); tick();                            // cycle 13: mid-WAIT of 0x08
    check("l3_pre_busy", {31'd0, busy3}, 32'd1);
    check("l3_pre_pc", {24'd0, pc3}, 32'h04);
    #3;
    rst3 = 1'b1;
    #1;
    check("l3_rst_valid", {31'd0, valid3}, 32'd0);
    check("l3_rst_busy", {31'd0, busy3}, 32'd0);
    check("l3_rst_pc", {24'd0, pc3}, 32'h00);
    check("l3_rst_instr", instr3, 32'h0);
    check("l3_rst_addr", {24'd0, addr3}, 32'h00);
    tick();
    rst3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
